// File: rtl/sram_port_ctrl.sv
// Front end for a single-port masked-write SRAM: clears the array after reset,
// then arbitrates write/read requests and returns read data through a 2-deep FIFO.
module sram_port_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 84,
    parameter int MASK_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [MASK_W-1:0] w_mask,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    input  logic              r_resp_ready,
    output logic [DATA_W-1:0] r_resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] sweep_cnt_reg, sweep_cnt_next;
    logic              inflight_reg;
    logic [1:0]        fifo_count_reg;
    logic              fifo_wr_ptr_reg;
    logic              fifo_rd_ptr_reg;
    logic [DATA_W-1:0] fifo_mem [2];

    logic       run;
    logic       enq;
    logic       deq;
    logic       w_fire;
    logic       r_fire;
    logic [2:0] occupancy;

    assign run          = (state_reg == ST_RUN);
    assign init_done    = run;
    assign r_resp_valid = (fifo_count_reg != 2'd0);
    assign r_resp_data  = fifo_mem[fifo_rd_ptr_reg];
    assign enq          = inflight_reg;
    assign deq          = r_resp_valid && r_resp_ready;

    // Slots already committed next cycle: buffered + in flight, minus one leaving now.
    assign occupancy   = {1'b0, fifo_count_reg} + {2'b00, inflight_reg} - {2'b00, deq};
    assign w_ready     = run;
    assign r_req_ready = run && !w_valid && (occupancy < 3'd2);
    assign w_fire      = w_valid && w_ready;
    assign r_fire      = r_req_valid && r_req_ready;

    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        if (state_reg == ST_INIT) begin
            if (sweep_cnt_reg == {ADDR_W{1'b1}}) begin
                state_next = ST_RUN;
            end else begin
                sweep_cnt_next = sweep_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        // The reset_n term keeps the SRAM idle while reset is held.
        if (!reset_n) begin
            sram_en = 1'b0;
        end else if (state_reg == ST_INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_cnt_reg;
            sram_wmask = '1;
            sram_wdata = '0;
        end else if (w_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wmask = w_mask;
            sram_wdata = w_data;
        end else if (r_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b0;
            sram_addr  = r_req_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_INIT;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_reg    <= 1'b0;
            fifo_count_reg  <= 2'd0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
        end else begin
            inflight_reg <= r_fire;
            if (enq) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (deq) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            if (enq && !deq) begin
                fifo_count_reg <= fifo_count_reg + 2'd1;
            end else if (!enq && deq) begin
                fifo_count_reg <= fifo_count_reg - 2'd1;
            end
        end
    end

    // Payload storage carries no reset; validity lives entirely in fifo_count_reg.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_mem[fifo_wr_ptr_reg] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural masked-write SRAM attached.
module tb_sram_port_ctrl;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 84;
    localparam int MASK_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int LW     = DATA_W / MASK_W;

    logic              clock;
    logic              reset_n;
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [MASK_W-1:0] w_mask;
    logic [DATA_W-1:0] w_data;
    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_resp_valid;
    logic              r_resp_ready;
    logic [DATA_W-1:0] r_resp_data;
    logic              init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [MASK_W-1:0] sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int checks;
    int failures;
    int stale;

    sram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_addr       (w_addr),
        .w_mask       (w_mask),
        .w_data       (w_data),
        .r_req_valid  (r_req_valid),
        .r_req_ready  (r_req_ready),
        .r_req_addr   (r_req_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_ready (r_resp_ready),
        .r_resp_data  (r_resp_data),
        .init_done    (init_done),
        .sram_addr    (sram_addr),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SRAM model starts full of ones so only the clear sweep can zero it.
    logic [DATA_W-1:0] sram_mem [DEPTH];
    logic [DATA_W-1:0] merged;
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = '1;
        sram_rdata = '0;
    end
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                merged = sram_mem[sram_addr];
                for (int l = 0; l < MASK_W; l++)
                    if (sram_wmask[l]) merged[l*LW +: LW] = sram_wdata[l*LW +: LW];
                sram_mem[sram_addr] <= merged;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    function automatic logic [DATA_W-1:0] dval(input int i);
        return {20'(i) ^ 20'hABCDE, 32'hC0DE0000 | 32'(i), 32'(i * 3 + 1)};
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; stale = 0;
        w_valid = 0; w_addr = '0; w_mask = '0; w_data = '0;
        r_req_valid = 0; r_req_addr = '0; r_resp_ready = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check1("rst_init_done", init_done, 1'b0);
        check1("rst_resp_valid", r_resp_valid, 1'b0);
        check1("rst_w_ready", w_ready, 1'b0);
        check1("rst_r_req_ready", r_req_ready, 1'b0);
        check1("rst_sram_en", sram_en, 1'b0);

        // Clear sweep: cycle 0 is the partial cycle right after release.
        reset_n = 1'b1;
        #1;
        check1("sweep0_en", sram_en, 1'b1);
        check1("sweep0_wmode", sram_wmode, 1'b1);
        checkv("sweep0_addr", DATA_W'(sram_addr), DATA_W'(0));
        checkv("sweep0_wmask", DATA_W'(sram_wmask), DATA_W'(4'hF));
        checkv("sweep0_wdata", sram_wdata, '0);
        check1("sweep0_w_ready", w_ready, 1'b0);
        check1("sweep0_r_req_ready", r_req_ready, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            next();
            #1;
            checkv("sweep_addr", DATA_W'(sram_addr), DATA_W'(i));
            check1("sweep_en", sram_en, 1'b1);
        end
        check1("sweep127_init_done", init_done, 1'b0);
        next();
        #1;
        check1("run_init_done", init_done, 1'b1);
        check1("run_w_ready", w_ready, 1'b1);
        check1("run_r_req_ready", r_req_ready, 1'b1);
        check1("run_idle_en", sram_en, 1'b0);

        // Masked write to 5 collides with a read; read goes next cycle.
        next();
        w_valid = 1; w_addr = 5; w_mask = 4'b0101; w_data = {4{21'h1AAAAA}};
        r_req_valid = 1; r_req_addr = 5; r_resp_ready = 1;
        #1;
        check1("wr_w_ready", w_ready, 1'b1);
        check1("wr_prio_r_req_ready", r_req_ready, 1'b0);
        check1("wr_en", sram_en, 1'b1);
        check1("wr_wmode", sram_wmode, 1'b1);
        checkv("wr_addr", DATA_W'(sram_addr), DATA_W'(5));
        checkv("wr_wmask", DATA_W'(sram_wmask), DATA_W'(4'b0101));
        checkv("wr_wdata", sram_wdata, {4{21'h1AAAAA}});
        next();
        w_valid = 0;
        #1;
        check1("rd_r_req_ready", r_req_ready, 1'b1);
        check1("rd_en", sram_en, 1'b1);
        check1("rd_wmode", sram_wmode, 1'b0);
        checkv("rd_addr", DATA_W'(sram_addr), DATA_W'(5));
        next();
        r_req_valid = 0;
        #1;
        check1("rd_lat1_valid", r_resp_valid, 1'b0);
        check1("rd_lat1_en", sram_en, 1'b0);
        next();
        #1;
        check1("rd_lat2_valid", r_resp_valid, 1'b1);
        checkv("rd_masked_data", r_resp_data, {21'h0, 21'h1AAAAA, 21'h0, 21'h1AAAAA});
        next();
        #1;
        check1("rd_after_valid", r_resp_valid, 1'b0);

        // Backpressure: FIFO fills after two reads, third waits.
        for (int i = 1; i <= 3; i++) begin
            next();
            w_valid = 1; w_addr = ADDR_W'(i); w_mask = 4'hF; w_data = dval(i);
        end
        next();
        w_valid = 0; r_resp_ready = 0; r_req_valid = 1; r_req_addr = 1;
        #1;
        check1("bp_accept1", r_req_ready, 1'b1);
        next();
        r_req_addr = 2;
        #1;
        check1("bp_accept2", r_req_ready, 1'b1);
        next();
        r_req_addr = 3;
        #1;
        check1("bp_block3a", r_req_ready, 1'b0);
        next();
        #1;
        check1("bp_block3b", r_req_ready, 1'b0);
        check1("bp_head_valid", r_resp_valid, 1'b1);
        checkv("bp_head_data", r_resp_data, dval(1));
        next();
        r_resp_ready = 1;
        #1;
        check1("bp_resp1_valid", r_resp_valid, 1'b1);
        checkv("bp_resp1_data", r_resp_data, dval(1));
        check1("bp_accept3", r_req_ready, 1'b1);
        next();
        r_req_valid = 0;
        #1;
        check1("bp_resp2_valid", r_resp_valid, 1'b1);
        checkv("bp_resp2_data", r_resp_data, dval(2));
        next();
        #1;
        check1("bp_resp3_valid", r_resp_valid, 1'b1);
        checkv("bp_resp3_data", r_resp_data, dval(3));
        next();
        #1;
        check1("bp_drained", r_resp_valid, 1'b0);

        // Streaming reads at full rate.
        for (int i = 0; i < 16; i++) begin
            next();
            w_valid = 1; w_addr = ADDR_W'(i); w_mask = 4'hF; w_data = dval(i + 40);
        end
        for (int i = 0; i < 16; i++) begin
            next();
            w_valid = 0; r_req_valid = 1; r_req_addr = ADDR_W'(i);
            #1;
            check1("stream_accept", r_req_ready, 1'b1);
            if (i >= 2) begin
                check1("stream_valid", r_resp_valid, 1'b1);
                checkv("stream_data", r_resp_data, dval(i - 2 + 40));
            end else begin
                check1("stream_early_valid", r_resp_valid, 1'b0);
            end
        end
        next();
        r_req_valid = 0;
        #1;
        checkv("stream_data14", r_resp_data, dval(14 + 40));
        next();
        #1;
        checkv("stream_data15", r_resp_data, dval(15 + 40));
        next();
        #1;
        check1("stream_done", r_resp_valid, 1'b0);

        // Reset with one response buffered and one in flight.
        next();
        r_resp_ready = 0; r_req_valid = 1; r_req_addr = 7;
        #1;
        check1("rr_accept7", r_req_ready, 1'b1);
        next();
        r_req_addr = 8;
        #1;
        check1("rr_accept8", r_req_ready, 1'b1);
        next();
        r_req_valid = 0;
        #1;
        check1("rr_buffered", r_resp_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("rr_valid_drop", r_resp_valid, 1'b0);
        check1("rr_en_low", sram_en, 1'b0);
        check1("rr_init_done", init_done, 1'b0);
        next();
        next();
        reset_n = 1'b1; r_resp_ready = 1;
        #1;
        checkv("rr_restart_addr", DATA_W'(sram_addr), DATA_W'(0));
        check1("rr_restart_en", sram_en, 1'b1);
        repeat (20) next();
        #1;
        checkv("rr_mid_addr", DATA_W'(sram_addr), DATA_W'(20));
        reset_n = 1'b0;
        next();
        reset_n = 1'b1;
        #1;
        checkv("midsweep_restart_addr", DATA_W'(sram_addr), DATA_W'(0));
        for (int k = 1; k <= DEPTH; k++) begin
            next();
            #1;
            if (r_resp_valid) stale++;
            if (k == DEPTH - 1) check1("rr_sweep_end_init_done", init_done, 1'b0);
        end
        check1("rr_init_done_again", init_done, 1'b1);
        repeat (4) begin
            next();
            #1;
            if (r_resp_valid) stale++;
        end
        checkv("rr_no_stale", DATA_W'(stale), DATA_W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
